// File: rtl/team_08_lfsr_rng.sv
// team_08_lfsr_rng: WIDTH-bit maximal-length Galois LFSR random source.
// Features: programmable step divider, runtime reseed, zero-lockup guard,
// and a req/valid sample port.
// Optional feature macro: RNG_ENTROPY_MIX_EN. When defined, a rising edge on
// the entropy input while running XORs a free-running cycle counter into the
// LFSR.
module team_08_lfsr_rng #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
  parameter logic [WIDTH-1:0] SEED  = 16'hACE1,
  parameter int               OUT_W = 2,
  parameter int               DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             reseed,
  input  logic [WIDTH-1:0] seed_in,
  input  logic [DIV_W-1:0] div_max,
  input  logic             entropy,
  input  logic             req,
  output logic [OUT_W-1:0] rnd,
  output logic             rnd_valid,
  output logic [WIDTH-1:0] lfsr_q
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_LOAD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lfsr_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [OUT_W-1:0] rnd_q, rnd_d;
  logic             rnd_valid_q, rnd_valid_d;
  logic             ent_rise;
  logic [WIDTH-1:0] free_cnt;

  // One Galois shift: shift right, fold the feedback mask in when bit 0 was set.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
    lfsr_step = (v >> 1) ^ (v[0] ? TAPS : '0);
  endfunction

  // An all-zero state would lock the LFSR forever; fall back to SEED instead.
  function automatic logic [WIDTH-1:0] zero_guard(input logic [WIDTH-1:0] v);
    zero_guard = (v == '0) ? SEED : v;
  endfunction

`ifdef RNG_ENTROPY_MIX_EN
  logic             ent_s1_q, ent_s1_d;
  logic             ent_s2_q, ent_s2_d;
  logic [WIDTH-1:0] free_cnt_q, free_cnt_d;

  // Edge-detector shift and free-running counter next-state.
  always_comb begin
    ent_s1_d   = entropy;
    ent_s2_d   = ent_s1_q;
    free_cnt_d = free_cnt_q + WIDTH'(1);
  end

  // Entropy edge detector and free counter registers; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      ent_s1_q   <= 1'b0;
      ent_s2_q   <= 1'b0;
      free_cnt_q <= '0;
    end else begin
      ent_s1_q   <= ent_s1_d;
      ent_s2_q   <= ent_s2_d;
      free_cnt_q <= free_cnt_d;
    end
  end

  assign ent_rise = ent_s1_q & ~ent_s2_q;
  assign free_cnt = free_cnt_q;
`else
  logic unused_entropy;
  assign unused_entropy = entropy;
  assign ent_rise       = 1'b0;
  assign free_cnt       = '0;
`endif

  // Next-state logic for FSM, divider, LFSR and sample port.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    div_cnt_d   = div_cnt_q;
    rnd_d       = rnd_q;
    rnd_valid_d = req;
    if (req) begin
      // IDLE reports SEED even on the first IDLE cycle after a LOAD.
      rnd_d = (state_q == ST_IDLE) ? SEED[OUT_W-1:0] : lfsr_q[OUT_W-1:0];
    end
    case (state_q)
      ST_IDLE: begin
        lfsr_d    = SEED;
        div_cnt_d = '0;
        if (reseed)   state_d = ST_LOAD;
        else if (run) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (reseed) begin
          // Load beats a coincident tick: LFSR holds this cycle.
          state_d   = ST_LOAD;
          div_cnt_d = '0;
        end else if (!run) begin
          state_d   = ST_IDLE;
          lfsr_d    = SEED;
          div_cnt_d = '0;
        end else begin
          if (div_cnt_q > div_max) begin
            // div_max lowered below the running count: restart without a step.
            div_cnt_d = '0;
          end else if (div_cnt_q == div_max) begin
            div_cnt_d = '0;
            lfsr_d    = lfsr_step(lfsr_q);
          end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
          end
          if (ent_rise) lfsr_d = lfsr_d ^ free_cnt;
        end
      end
      ST_LOAD: begin
        lfsr_d    = (seed_in == '0) ? SEED : seed_in;
        div_cnt_d = '0;
        if (reseed)   state_d = ST_LOAD;
        else if (run) state_d = ST_RUN;
        else          state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        lfsr_d    = SEED;
        div_cnt_d = '0;
      end
    endcase
    lfsr_d = zero_guard(lfsr_d);
  end

  // State registers; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      lfsr_q      <= SEED;
      div_cnt_q   <= '0;
      rnd_q       <= '0;
      rnd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      div_cnt_q   <= div_cnt_d;
      rnd_q       <= rnd_d;
      rnd_valid_q <= rnd_valid_d;
    end
  end

  assign rnd       = rnd_q;
  assign rnd_valid = rnd_valid_q;

endmodule

// File: tb/tb_team_08_lfsr_rng.sv
// Self-checking bench for team_08_lfsr_rng: a behavioural model checked
// every cycle, plus directed vectors with hand-computed values.
module tb_team_08_lfsr_rng;
  localparam int          WIDTH = 16;
  localparam logic [15:0] TAPS  = 16'hB400;
  localparam logic [15:0] SEED  = 16'hACE1;
  localparam int          OUT_W = 2;
  localparam int          DIV_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             run = 1'b0;
  logic             reseed = 1'b0;
  logic [WIDTH-1:0] seed_in = '0;
  logic [DIV_W-1:0] div_max = '0;
  logic             entropy = 1'b0;
  logic             req = 1'b0;
  logic [OUT_W-1:0] rnd;
  logic             rnd_valid;
  logic [WIDTH-1:0] lfsr_q;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  team_08_lfsr_rng #(
    .WIDTH(WIDTH), .TAPS(TAPS), .SEED(SEED), .OUT_W(OUT_W), .DIV_W(DIV_W)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .reseed(reseed), .seed_in(seed_in),
    .div_max(div_max), .entropy(entropy), .req(req), .rnd(rnd),
    .rnd_valid(rnd_valid), .lfsr_q(lfsr_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle (held at seed), 1 running, 2 loading a seed
  int          m_mode = 0;
  int          m_cnt = 0;
  int unsigned m_lfsr = SEED;
  int unsigned m_rnd = 0;
  int unsigned m_vld = 0;
  int unsigned m_fc = 0;
  bit          m_e1 = 0, m_e2 = 0;

  function automatic int unsigned galois(input int unsigned v);
    int unsigned r;
    r = v / 2;
    if (v % 2 == 1) r = r ^ TAPS;
    return r;
  endfunction

  always @(posedge clk) begin
    int unsigned nl;
    int          nmode;
    if (reset) begin
      m_mode = 0; m_cnt = 0; m_lfsr = SEED; m_rnd = 0; m_vld = 0;
      m_fc = 0; m_e1 = 0; m_e2 = 0;
    end else begin
      m_vld = req;
      if (req) m_rnd = (m_mode == 0) ? (SEED % 4) : (m_lfsr % 4);
      nl = m_lfsr;
      nmode = m_mode;
      if (m_mode == 0) begin
        nl = SEED; m_cnt = 0;
        nmode = reseed ? 2 : (run ? 1 : 0);
      end else if (m_mode == 2) begin
        nl = (seed_in == 0) ? SEED : seed_in; m_cnt = 0;
        nmode = reseed ? 2 : (run ? 1 : 0);
      end else if (reseed) begin
        nmode = 2; m_cnt = 0;
      end else if (!run) begin
        nmode = 0; nl = SEED; m_cnt = 0;
      end else begin
        if (m_cnt > int'(div_max)) m_cnt = 0;
        else if (m_cnt == int'(div_max)) begin m_cnt = 0; nl = galois(m_lfsr); end
        else m_cnt = m_cnt + 1;
`ifdef RNG_ENTROPY_MIX_EN
        if (m_e1 && !m_e2) nl = nl ^ (m_fc % 65536);
`endif
      end
      if (nl == 0) nl = SEED;
      m_lfsr = nl;
      m_mode = nmode;
      m_e2 = m_e1; m_e1 = entropy; m_fc = m_fc + 1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_lfsr", 32'(lfsr_q), m_lfsr);
      chk("model_rnd", 32'(rnd), m_rnd);
      chk("model_valid", 32'(rnd_valid), m_vld);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int       n;
    bit       zero_seen;
    bit [3:0] seen;
    logic [WIDTH-1:0] prev;

    // Reset with run already high: reset must win.
    run = 1'b1;
    step();
    cmp_en = 1'b1;
    step();
    chk("reset_lfsr", 32'(lfsr_q), 32'hACE1);
    chk("reset_rnd", 32'(rnd), 0);
    chk("reset_valid", 32'(rnd_valid), 0);

    // Release: IDLE -> RUN, then step every cycle.
    reset = 1'b0;
    step();
    chk("run_entry_lfsr", 32'(lfsr_q), 32'hACE1);
    step();
    chk("seq_e270", 32'(lfsr_q), 32'hE270);
    req = 1'b1;
    step();
    chk("seq_7138", 32'(lfsr_q), 32'h7138);
    chk("req_rnd", 32'(rnd), 0);
    chk("req_valid", 32'(rnd_valid), 1);
    req = 1'b0;
    step();
    chk("valid_drop", 32'(rnd_valid), 0);
    chk("rnd_hold", 32'(rnd), 0);

    // Divider: change every 4th cycle.
    div_max = 8'd3;
    prev = lfsr_q;
    for (int i = 1; i <= 12; i++) begin
      step();
      chk("div4_change", 32'(lfsr_q != prev), 32'((i % 4) == 0));
      prev = lfsr_q;
    end

    // Drop run -> IDLE, held at SEED; IDLE request returns SEED bits.
    run = 1'b0;
    step();
    chk("idle_seed", 32'(lfsr_q), 32'hACE1);
    req = 1'b1;
    step();
    chk("idle_rnd", 32'(rnd), 1);
    req = 1'b0;

    // Reseed with 0001, then tick -> B400.
    run = 1'b1; div_max = 8'd0; seed_in = 16'h0001; reseed = 1'b1;
    step();
    reseed = 1'b0;
    step();
    chk("load_0001", 32'(lfsr_q), 32'h0001);
    step();
    chk("step_b400", 32'(lfsr_q), 32'hB400);

    // Reseed with a tick due: load wins, no step; seed 0 maps to SEED.
    seed_in = '0; reseed = 1'b1;
    step();
    chk("reseed_no_step", 32'(lfsr_q), 32'hB400);
    reseed = 1'b0;
    step();
    chk("seed0_to_seed", 32'(lfsr_q), 32'hACE1);

    // div_max lowered below the running count (model checks the wrap).
    div_max = 8'd5;
    repeat (5) step();
    div_max = 8'd2;
    repeat (6) step();

    // Entropy toggling while running (ignored unless the mix is built in).
    div_max = 8'd0;
    for (int i = 0; i < 10; i++) begin
      entropy = ~entropy;
      step();
    end

    // Reset mid-RUN with req high.
    req = 1'b1; reset = 1'b1;
    step();
    chk("midreset_lfsr", 32'(lfsr_q), 32'hACE1);
    chk("midreset_rnd", 32'(rnd), 0);
    chk("midreset_valid", 32'(rnd_valid), 0);
    reset = 1'b0; entropy = 1'b0;

    // Full period, requesting every cycle.
    step();
    chk("period_start", 32'(lfsr_q), 32'hACE1);
    n = 0; zero_seen = 0; seen = '0;
    do begin
      step();
      n++;
      if (lfsr_q == '0) zero_seen = 1;
      seen[rnd] = 1'b1;
    end while (lfsr_q != 16'hACE1 && n < 70000);
    chk("period_len", n, 65535);
    chk("never_zero", 32'(zero_seen), 0);
    chk("all_rnd_seen", 32'(seen), 32'hF);

    req = 1'b0;
    step();
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
